// File: rtl/sap_register_file.sv
// SAP-style general register file: a manual step button (synchronised and edge-detected)
// executes one HOLD/LOAD/INC/DEC operation on a selected register, with a tri-state bus port.
module sap_register_file #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      NUM_REGS    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned     ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic              oe,
  input  logic [ADDR_W-1:0] rd_sel,
  inout  logic [WIDTH-1:0]  bus,
  output logic [WIDTH-1:0]  disp_out,
  output logic              zero,
  output logic              carry,
  output logic              ack,
  output logic              err
);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } op_e;

  op_e              op_cmd;
  logic             s1, s2, s3;
  logic             fire;
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;

  assign op_cmd  = op_e'(op);
  assign fire    = s2 & ~s3;
  assign cur_val = regs[wr_sel];
  assign inc_val = cur_val + WIDTH'(1);
  assign dec_val = cur_val - WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      zero  <= 1'b0;
      carry <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else begin
      s1  <= step;
      s2  <= s1;
      s3  <= s2;
      ack <= fire;
      if (fire) begin
        unique case (op_cmd)
          OP_HOLD: ;
          // A LOAD while this block drives the bus would read back its own value; flag it instead.
          OP_LOAD: begin
            if (oe) begin
              err <= 1'b1;
            end else begin
              regs[wr_sel] <= bus;
              zero         <= (bus == '0);
              carry        <= 1'b0;
            end
          end
          OP_INC: begin
            regs[wr_sel] <= inc_val;
            carry        <= (cur_val == '1);
            zero         <= (inc_val == '0);
          end
          OP_DEC: begin
            regs[wr_sel] <= dec_val;
            carry        <= (cur_val == '0);
            zero         <= (dec_val == '0);
          end
          default: ;
        endcase
      end
    end
  end

  assign disp_out = regs[rd_sel];
  assign bus      = oe ? regs[rd_sel] : 'z;

endmodule

// File: tb/tb_sap_register_file.sv
// Self-checking bench for sap_register_file: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the step/operation rules.
module tb_sap_register_file;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b0;
  logic [1:0] op = 2'b00;
  logic [1:0] wr_sel = 2'd0;
  logic       oe = 1'b0;
  logic [1:0] rd_sel = 2'd0;
  logic [7:0] bus_drv = 8'h00;
  wire  [7:0] bus;
  logic [7:0] disp_out;
  logic       zero, carry, ack, err;

  int checks = 0;
  int passes = 0;
  int ack_seen = 0;

  // The bench drives the bus whenever the DUT is not asked to.
  assign bus = oe ? 'z : bus_drv;

  sap_register_file #(
    .WIDTH(8),
    .NUM_REGS(4),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step(step),
    .op(op),
    .wr_sel(wr_sel),
    .oe(oe),
    .rd_sel(rd_sel),
    .bus(bus),
    .disp_out(disp_out),
    .zero(zero),
    .carry(carry),
    .ack(ack),
    .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a rising step seen at edge N executes its operation at edge N+2.
  logic [7:0] m_reg [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  bit m_zero = 0, m_carry = 0, m_ack = 0, m_err = 0;
  bit prev_step = 0;
  int cyc = 0;
  int exec_at[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_zero = 0; m_carry = 0; m_ack = 0; m_err = 0;
      prev_step = 0;
      exec_at.delete();
    end else begin
      cyc++;
      m_ack = 0;
      if (exec_at.size() > 0 && exec_at[0] == cyc) begin
        int old_v, new_v;
        void'(exec_at.pop_front());
        m_ack = 1;
        old_v = int'(m_reg[wr_sel]);
        case (op)
          2'b01: begin
            if (oe) m_err = 1;
            else begin
              m_reg[wr_sel] = bus_drv;
              m_zero  = (bus_drv == 8'h00);
              m_carry = 0;
            end
          end
          2'b10: begin
            new_v = (old_v + 1) % 256;
            m_reg[wr_sel] = 8'(new_v);
            m_carry = (old_v == 255);
            m_zero  = (new_v == 0);
          end
          2'b11: begin
            new_v = (old_v + 255) % 256;
            m_reg[wr_sel] = 8'(new_v);
            m_carry = (old_v == 0);
            m_zero  = (new_v == 0);
          end
          default: ;
        endcase
      end
      if (step && !prev_step) exec_at.push_back(cyc + 2);
      prev_step = step;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (ack === 1'b1) ack_seen++;
    check("disp_out", 32'(disp_out), 32'(m_reg[rd_sel]));
    check("zero", 32'(zero), 32'(m_zero));
    check("carry", 32'(carry), 32'(m_carry));
    check("ack", 32'(ack), 32'(m_ack));
    check("err", 32'(err), 32'(m_err));
    if (oe) check("bus_drive", 32'(bus), 32'(m_reg[rd_sel]));
    else    check("bus_release", 32'(bus), 32'(bus_drv));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press();
    step = 1'b1;
    tick(3);
    step = 1'b0;
    tick(3);
  endtask

  initial begin
    int snap;
    // Reset state, checked before any clock edge.
    oe = 1'b1;
    #3;
    check("rst_disp", 32'(disp_out), 32'h00);
    check("rst_bus", 32'(bus), 32'h00);
    check("rst_flags", {28'd0, zero, carry, ack, err}, 32'h0);
    oe = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);

    // INC reg0 with exact latency.
    op = 2'b10; wr_sel = 2'd0; rd_sel = 2'd0;
    step = 1'b1;
    tick(1); check("lat_ack_n", 32'(ack), 32'h0);
    tick(1); check("lat_ack_n1", 32'(ack), 32'h0);
    check("lat_disp_n1", 32'(disp_out), 32'h00);
    tick(1); check("lat_ack_n2", 32'(ack), 32'h1);
    check("inc_disp", 32'(disp_out), 32'h01);
    check("inc_zc", {30'd0, zero, carry}, 32'h0);
    step = 1'b0;
    tick(1); check("ack_one_cycle", 32'(ack), 32'h0);
    tick(2);

    // LOAD 0x42 into reg2, read it back over the bus.
    oe = 1'b0; bus_drv = 8'h42; op = 2'b01; wr_sel = 2'd2;
    press();
    rd_sel = 2'd2; oe = 1'b1;
    #1;
    check("load_bus", 32'(bus), 32'h42);
    check("load_disp", 32'(disp_out), 32'h42);

    // Wrap-around on reg1.
    oe = 1'b0; bus_drv = 8'hFF; op = 2'b01; wr_sel = 2'd1; rd_sel = 2'd1;
    press();
    op = 2'b10; press();
    check("inc_wrap_val", 32'(disp_out), 32'h00);
    check("inc_wrap_zc", {30'd0, zero, carry}, 32'h3);
    op = 2'b11; press();
    check("dec_wrap_val", 32'(disp_out), 32'hFF);
    check("dec_wrap_zc", {30'd0, zero, carry}, 32'h1);

    // Long hold gives one increment; a second press gives another.
    op = 2'b10; wr_sel = 2'd3; rd_sel = 2'd3;
    ack_seen = 0;
    step = 1'b1; tick(20); step = 1'b0; tick(3);
    check("hold_acks", 32'(ack_seen), 32'd1);
    check("hold_val", 32'(disp_out), 32'h01);
    press();
    check("repress_val", 32'(disp_out), 32'h02);
    check("repress_acks", 32'(ack_seen), 32'd2);

    // LOAD with oe=1 is refused and sets sticky err.
    oe = 1'b1; op = 2'b01; wr_sel = 2'd3;
    press();
    check("loadoe_val", 32'(disp_out), 32'h02);
    check("loadoe_err", 32'(err), 32'h1);
    oe = 1'b0; op = 2'b10;
    press();
    check("err_sticky", 32'(err), 32'h1);
    check("err_sticky_val", 32'(disp_out), 32'h03);

    // Reset while a step is in flight discards it.
    op = 2'b10; wr_sel = 2'd0; rd_sel = 2'd0;
    snap = ack_seen;
    step = 1'b1;
    tick(1);
    reset = 1'b1;
    #1;
    check("async_rst_disp", 32'(disp_out), 32'h00);
    check("async_rst_err", 32'(err), 32'h0);
    tick(1);
    reset = 1'b0; step = 1'b0;
    tick(5);
    check("discard_acks", 32'(ack_seen), 32'(snap));
    check("discard_val", 32'(disp_out), 32'h00);

    // Random stimulus, checked every cycle by the compare process.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) step = ~step;
      op      = 2'($urandom_range(0, 3));
      wr_sel  = 2'($urandom_range(0, 3));
      rd_sel  = 2'($urandom_range(0, 3));
      oe      = ($urandom_range(0, 3) == 0);
      bus_drv = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      reset   = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
